// File: rtl/patch_embed_pkg.sv
// Shared types, defaults and the spike field-sum helper for the patch-embedding stage.
package patch_embed_pkg;

    localparam int unsigned SPK_W_DEF     = 32;
    localparam int unsigned FRAME_LEN_DEF = 64;
    localparam int unsigned DEPTH_DEF     = 4096;
    localparam int unsigned MAX_SPK_W     = 64;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    // Per-bit half-adder of fmap and patch spikes: field k = {carry, sum} at [2k+1:2k].
    function automatic logic [2*MAX_SPK_W-1:0] field_sum(
        input logic [MAX_SPK_W-1:0] fmap,
        input logic [MAX_SPK_W-1:0] patch
    );
        logic [2*MAX_SPK_W-1:0] f;
        f = '0;
        for (int k = 0; k < int'(MAX_SPK_W); k++) begin
            f[2*k+1] = fmap[k] & patch[k];
            f[2*k]   = fmap[k] ^ patch[k];
        end
        return f;
    endfunction

endpackage

// File: rtl/pe_bank_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with 1-cycle latency.
module pe_bank_ram #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              s_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge s_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/patch_embed_pp.sv
// Double-buffered patch-embedding stage: spike field sums written into ping-pong frame banks.
// Define PATCH_EMBED_EXT_PORT_EN to add the external scratch-RAM port onto either bank.
module patch_embed_pp
    import patch_embed_pkg::*;
#(
    parameter int unsigned SPK_W     = SPK_W_DEF,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 s_clk,
    input  logic                 s_rst,
    input  logic                 i_data_valid,
    output logic                 o_in_ready,
    input  logic [SPK_W-1:0]     i_fmap,
    input  logic [SPK_W-1:0]     i_patch,
    output logic                 o_rd_ready,
    output logic                 o_rd_bank,
    input  logic                 i_rd_en,
    input  logic [ADDR_W-1:0]    i_rd_addr,
    output logic [2*SPK_W-1:0]   o_rd_data,
    output logic                 o_rd_valid,
    input  logic                 i_rd_release,
    output logic [15:0]          o_frame_cnt
`ifdef PATCH_EMBED_EXT_PORT_EN
    ,
    input  logic                 i_ext_en,
    input  logic                 i_ext_bank,
    input  logic                 i_ext_we,
    input  logic [ADDR_W-1:0]    i_ext_addr,
    input  logic [2*SPK_W-1:0]   i_ext_din,
    output logic [2*SPK_W-1:0]   o_ext_dout
`endif
);

    localparam int unsigned       WORD_W = 2 * SPK_W;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(FRAME_LEN - 1);

    logic                 in_sel;
    logic [ADDR_W-1:0]    in_cnt;
    logic                 wr_valid;
    logic                 wr_sel;
    logic [ADDR_W-1:0]    wr_cnt;
    logic [WORD_W-1:0]    wr_word;
    logic                 rd_sel;
    logic                 rd_en_q;
    logic                 rd_bank_q;
    logic [1:0]           full;
    logic [1:0]           ext_hit;
    bank_state_t          state_q [2];
    bank_state_t          state_d [2];

    logic [1:0]           ram_we;
    logic [ADDR_W-1:0]    ram_waddr [2];
    logic [ADDR_W-1:0]    ram_raddr [2];
    logic [WORD_W-1:0]    ram_wdata [2];
    logic [WORD_W-1:0]    ram_rdata [2];

    logic accept;
    logic release_ok;
    logic commit_last;

`ifdef PATCH_EMBED_EXT_PORT_EN
    logic ext_bank_q;

    assign ext_hit = i_ext_en ? (i_ext_bank ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) ext_bank_q <= 1'b0;
        else       ext_bank_q <= i_ext_bank;
    end

    assign o_ext_dout = ram_rdata[ext_bank_q];
`else
    assign ext_hit = 2'b00;
`endif

    assign o_in_ready  = ~full[in_sel] & ~ext_hit[in_sel];
    assign o_rd_ready  = full[rd_sel] & ~ext_hit[rd_sel];
    assign o_rd_bank   = rd_sel;
    assign accept      = i_data_valid & o_in_ready;
    assign release_ok  = i_rd_release & full[rd_sel];
    assign commit_last = wr_valid & (wr_cnt == LAST);

    // Input stage: register the summed word with its bank/address for next-edge commit.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            in_sel   <= 1'b0;
            in_cnt   <= '0;
            wr_valid <= 1'b0;
            wr_sel   <= 1'b0;
            wr_cnt   <= '0;
            wr_word  <= '0;
        end else begin
            wr_valid <= accept;
            if (accept) begin
                wr_word <= WORD_W'(field_sum(MAX_SPK_W'(i_fmap), MAX_SPK_W'(i_patch)));
                wr_sel  <= in_sel;
                wr_cnt  <= in_cnt;
                if (in_cnt == LAST) begin
                    in_cnt <= '0;
                    in_sel <= ~in_sel;
                end else begin
                    in_cnt <= in_cnt + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
        end
    end

    // Per-bank status; a release and the other bank's last commit land independently.
    always_comb begin
        full = 2'b00;
        for (int unsigned b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            case (state_q[b])
                EMPTY:   if (wr_valid && wr_sel == 1'(b) && wr_cnt == '0) state_d[b] = FILLING;
                FILLING: if (commit_last && wr_sel == 1'(b))              state_d[b] = FULL;
                FULL:    if (release_ok && rd_sel == 1'(b))               state_d[b] = EMPTY;
                default: state_d[b] = EMPTY;
            endcase
            full[b] = (state_q[b] == FULL);
        end
    end

    // Bank port steering: embed path by default, external port overrides its bank.
    always_comb begin
        for (int unsigned b = 0; b < 2; b++) begin
            ram_we[b]    = wr_valid & (wr_sel == 1'(b));
            ram_waddr[b] = wr_cnt;
            ram_wdata[b] = wr_word;
            ram_raddr[b] = i_rd_addr;
`ifdef PATCH_EMBED_EXT_PORT_EN
            if (ext_hit[b]) begin
                ram_we[b]    = i_ext_we;
                ram_waddr[b] = i_ext_addr;
                ram_wdata[b] = i_ext_din;
                ram_raddr[b] = i_ext_addr;
            end
`endif
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pe_bank_ram #(
            .DATA_W (WORD_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .s_clk (s_clk),
            .we    (ram_we[b]),
            .waddr (ram_waddr[b]),
            .wdata (ram_wdata[b]),
            .raddr (ram_raddr[b]),
            .rdata (ram_rdata[b])
        );
    end

    // Reader side: bank pointer, frame counter and 2-stage read pipeline.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            rd_sel      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_bank_q   <= 1'b0;
            o_rd_valid  <= 1'b0;
            o_rd_data   <= '0;
            o_frame_cnt <= '0;
        end else begin
            if (release_ok)  rd_sel      <= ~rd_sel;
            if (commit_last) o_frame_cnt <= o_frame_cnt + 16'd1;
            rd_en_q    <= i_rd_en;
            rd_bank_q  <= rd_sel;
            o_rd_valid <= rd_en_q;
            if (rd_en_q) o_rd_data <= ram_rdata[rd_bank_q];
        end
    end

endmodule
